// File: rtl/serial_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_pkg
// Description : Shared types and sizing helpers for serial_magnitude_comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

  // Controller state encoding
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_e;

  // Number of CHUNK-bit slices needed to cover WIDTH bits (ceiling divide)
  function automatic int num_chunks(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Bits needed to index the slices; never narrower than one bit
  function automatic int idx_width(input int n_chunks);
    return (n_chunks <= 1) ? 1 : $clog2(n_chunks);
  endfunction

endpackage : serial_cmp_pkg
`default_nettype wire

// File: rtl/serial_magnitude_comparator_chunk_compare.sv
`default_nettype none
// ============================================================================
// Module      : chunk_compare
// Description : Combinational magnitude compare of one CHUNK-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             a_gt_o,
  output logic             a_lt_o
);

  // Plain unsigned compare; sign handling happens once at operand capture
  always_comb begin
    a_gt_o = (a_i > b_i);
    a_lt_o = (a_i < b_i);
  end

endmodule : chunk_compare
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_magnitude_comparator
// Description : Multi-cycle MSB-first magnitude comparator with lt/eq/gt
//               cascade inputs. Scans CHUNK bits per cycle from the top and
//               stops at the first differing slice.
// Options     : SERIAL_CMP_SIGNED_EN - two's-complement operands (operand MSB
//               inverted on capture); undefined gives an unsigned compare.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int IDX_W      = idx_width(NUM_CHUNKS);
  localparam int PAD_W      = NUM_CHUNKS * CHUNK;
  localparam logic [IDX_W-1:0] C_TOP_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               lt_q, lt_d;
  logic               eq_q, eq_d;
  logic               gt_q, gt_d;
  logic [2:0]         casc_q, casc_d;     // captured {l,e,g}
  logic [PAD_W-1:0]   a_q, b_q;           // zero-padded operands

  logic [PAD_W-1:0]   a_ext_w, b_ext_w;
  logic [CHUNK-1:0]   a_chunk_w, b_chunk_w;
  logic               a_gt_w, a_lt_w;
  logic               accept_w;

  assign accept_w = (state_q == IDLE) && start;

  // Zero-extend operands to a whole number of slices; optionally bias the sign bit
  always_comb begin
    a_ext_w = '0;
    b_ext_w = '0;
    a_ext_w[WIDTH-1:0] = a;
    b_ext_w[WIDTH-1:0] = b;
`ifdef SERIAL_CMP_SIGNED_EN
    a_ext_w[WIDTH-1] = ~a[WIDTH-1];
    b_ext_w[WIDTH-1] = ~b[WIDTH-1];
`endif
  end

  // Operand capture on accepted start; contents are don't-care out of reset
  always_ff @(posedge clk) begin
    if (accept_w) begin
      a_q <= a_ext_w;
      b_q <= b_ext_w;
    end
  end

  // Select the slice under examination
  always_comb begin
    a_chunk_w = a_q[int'(idx_q) * CHUNK +: CHUNK];
    b_chunk_w = b_q[int'(idx_q) * CHUNK +: CHUNK];
  end

  chunk_compare #(
    .CHUNK (CHUNK)
  ) u_chunk_compare (
    .a_i    (a_chunk_w),
    .b_i    (b_chunk_w),
    .a_gt_o (a_gt_w),
    .a_lt_o (a_lt_w)
  );

  // Next-state and output logic for the scan controller
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    casc_d  = casc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          casc_d  = {l, e, g};
          idx_d   = C_TOP_IDX;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (a_gt_w) begin
          gt_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (a_lt_w) begin
          lt_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx_q != '0) begin
          idx_d   = idx_q - 1'b1;
        end else begin
          // All slices equal: forward the cascade inputs untouched
          lt_d    = casc_q[2];
          eq_d    = casc_q[1];
          gt_d    = casc_q[0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller and result registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      casc_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      casc_q  <= casc_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule : serial_magnitude_comparator
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_magnitude_comparator
// Description : Directed self-checking bench; a 32/4 instance and a 10/4
//               instance (padded top slice) share clock, reset and cascade.
// Options     : SERIAL_CMP_SIGNED_EN selects signed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_magnitude_comparator;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sel;          // 0: 32-bit instance, 1: 10-bit instance
  logic [31:0] a_tb, b_tb;
  logic        l_tb, e_tb, g_tb;

  logic        busy1, done1, lt1, eq1, gt1;
  logic        busy2, done2, lt2, eq2, gt2;
  logic        start1, start2;
  logic        busy_m, done_m, lt_m, eq_m, gt_m;

  int tests_run;
  int tests_failed;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;
  assign lt_m   = sel ? lt2   : lt1;
  assign eq_m   = sel ? eq2   : eq1;
  assign gt_m   = sel ? gt2   : gt1;

  serial_magnitude_comparator #(.WIDTH(32), .CHUNK(4)) u_dut32 (
    .clk (clk), .rst (rst), .start (start1),
    .a (a_tb), .b (b_tb), .l (l_tb), .e (e_tb), .g (g_tb),
    .busy (busy1), .done (done1), .lt (lt1), .eq (eq1), .gt (gt1)
  );

  serial_magnitude_comparator #(.WIDTH(10), .CHUNK(4)) u_dut10 (
    .clk (clk), .rst (rst), .start (start2),
    .a (a_tb[9:0]), .b (b_tb[9:0]), .l (l_tb), .e (e_tb), .g (g_tb),
    .busy (busy2), .done (done2), .lt (lt2), .eq (eq2), .gt (gt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands and start mid-cycle; return #1 after the accept edge
  task automatic launch(input string tag, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [2:0] leg);
    sel   = s;
    a_tb  = av;
    b_tb  = bv;
    {l_tb, e_tb, g_tb} = leg;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy after accept"}, {31'd0, busy_m}, 32'd1);
    check({tag, " done after accept"}, {31'd0, done_m}, 32'd0);
  endtask

  // Count cycles to done and check the result; optionally pulse a stray start
  task automatic wait_done(input string tag, input int exp_lat, input logic [2:0] exp_leg,
                           input int inj);
    int  cnt;
    bit  got;
    cnt = 0;
    got = 0;
    while (!got && cnt < 40) begin
      if (inj > 0 && cnt == inj) begin
        start = 1'b1;
        a_tb  = 32'hF000_0000;
        b_tb  = 32'h0000_0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (done_m) got = 1;
    end
    start = 1'b0;
    check({tag, " done seen"}, {31'd0, got}, 32'd1);
    check({tag, " latency"}, cnt, exp_lat);
    check({tag, " lt/eq/gt"}, {29'd0, lt_m, eq_m, gt_m}, {29'd0, exp_leg});
    check({tag, " busy at done"}, {31'd0, busy_m}, 32'd0);
  endtask

  initial begin
    int dones;
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    a_tb  = '0;
    b_tb  = '0;
    {l_tb, e_tb, g_tb} = 3'b000;
    #1;
    check("reset busy", {31'd0, busy1}, 32'd0);
    check("reset done", {31'd0, done1}, 32'd0);
    check("reset lt/eq/gt", {29'd0, lt1, eq1, gt1}, 32'd0);
    check("reset10 busy", {31'd0, busy2}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Decision in the top slice
    launch("t1", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b000);
`ifdef SERIAL_CMP_SIGNED_EN
    wait_done("t1", 1, 3'b100, 0);
`else
    wait_done("t1", 1, 3'b001, 0);
`endif

    // Equal operands pass the cascade through after every slice
    @(negedge clk);
    launch("t2l", 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b100);
    wait_done("t2l", 8, 3'b100, 0);
    @(negedge clk);
    launch("t2e", 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b010);
    wait_done("t2e", 8, 3'b010, 0);
    @(negedge clk);
    launch("t2g", 1'b0, 32'hCAFE_0001, 32'hCAFE_0001, 3'b001);
    wait_done("t2g", 8, 3'b001, 0);

    // Lowest slice decides; a start while busy must be ignored
    @(negedge clk);
    launch("t3", 1'b0, 32'h0000_0010, 32'h0000_0011, 3'b001);
    wait_done("t3", 8, 3'b100, 3);

    // Back-to-back: start in the done cycle
    launch("t4bb", 1'b0, 32'd5, 32'd3, 3'b000);
    wait_done("t4bb", 8, 3'b001, 0);

    // Reset in the middle of a run
    @(negedge clk);
    launch("t4rst", 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b010);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t4rst busy mid-run", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    #1;
    check("t4rst busy", {31'd0, busy1}, 32'd0);
    check("t4rst done", {31'd0, done1}, 32'd0);
    check("t4rst lt/eq/gt", {29'd0, lt1, eq1, gt1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done1) dones++;
    end
    check("t4rst no done", dones, 0);
    check("t4rst busy stays low", {31'd0, busy1}, 32'd0);

    // Sign handling in the top slice
    @(negedge clk);
    launch("t5", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000);
`ifdef SERIAL_CMP_SIGNED_EN
    wait_done("t5", 1, 3'b100, 0);
`else
    wait_done("t5", 1, 3'b001, 0);
`endif

    // 10-bit instance with a padded top slice
    @(negedge clk);
    launch("t6a", 1'b1, 32'h0000_03FF, 32'h0000_03FE, 3'b000);
    wait_done("t6a", 3, 3'b001, 0);
    @(negedge clk);
    launch("t6b", 1'b1, 32'h0000_0200, 32'h0000_0100, 3'b000);
`ifdef SERIAL_CMP_SIGNED_EN
    wait_done("t6b", 1, 3'b100, 0);
`else
    wait_done("t6b", 1, 3'b001, 0);
`endif
    @(negedge clk);
    launch("t6c", 1'b1, 32'h0000_0155, 32'h0000_0155, 3'b010);
    wait_done("t6c", 3, 3'b010, 0);

    // Result holds after done until the next accepted start
    sel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6c hold", {29'd0, lt2, eq2, gt2}, 32'd2);
    check("t6c done one-shot", {31'd0, done2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_magnitude_comparator
`default_nettype wire

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Multi-cycle magnitude comparator for wide operands. It compares CHUNK bits per clock, starting at the MSB end. The combinational comparators cascade from the LSB slice upward; this block scans the other direction and stops as soon as a chunk differs. It produces the same lt/eq/gt triple with cascade inputs, so the result can chain into existing comparator trees. Area is traded for latency.

Parameters:
WIDTH, 32, operand width in bits (>=1)
CHUNK, 4, bits compared per cycle (1..WIDTH)
NUM_CHUNKS, ceil(WIDTH/CHUNK), derived localparam; not user-set

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when busy=0
a  input  WIDTH  operand A; sampled on accepted start
b  input  WIDTH  operand B; sampled on accepted start
l  input  1  cascade-in less; sampled on accepted start
e  input  1  cascade-in equal; sampled on accepted start
g  input  1  cascade-in greater; sampled on accepted start
busy  output  1  comparison in progress
done  output  1  one-cycle pulse when result valid
lt  output  1  A<B result, held until next accepted start
eq  output  1  A==B result, held until next accepted start
gt  output  1  A>B result, held until next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: busy=0, done=0, lt=0, eq=0, gt=0, FSM=IDLE, chunk index=0. Operand registers are don't-care.
- FSM has two states, IDLE and COMPARE.
- IDLE:
  - start=1 captures a, b and {l,e,g} into registers.
  - Chunk index is set to NUM_CHUNKS-1. Go to COMPARE. busy=1 from the next cycle.
  - lt/eq/gt are cleared to 0 on acceptance.
- COMPARE, each cycle examines the chunk at the current index:
  - Chunk A > chunk B: register gt=1, done pulse, go to IDLE.
  - Chunk A < chunk B: register lt=1, done pulse, go to IDLE.
  - Chunks equal and index>0: decrement index, stay in COMPARE.
  - Chunks equal and index=0: outputs take the captured {l,e,g} unchanged (cascade pass-through, no one-hot check). done pulse, go to IDLE.
- Latency:
  - Decision at the k-th chunk from the MSB (k=1..NUM_CHUNKS): done and result appear k cycles after the start-accept edge.
  - Best case is 1 cycle; worst case is NUM_CHUNKS cycles.
- busy falls in the same cycle done rises.
- start with busy=1 is ignored and has no side effects.
- start in the done cycle is accepted (busy=0), allowing back-to-back operation. done then drops and busy rises on the next cycle.
- Padding: if WIDTH is not a multiple of CHUNK, the top chunk is zero-extended at its MSB end.
- Reset mid-operation: abort immediately, with all outputs at their reset values and no done pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
Macro: SERIAL_CMP_SIGNED_EN
- Defined: operands are two's complement. The operand MSB (bit WIDTH-1) is inverted on capture, so a=-1 is less than b=1. Latency is unchanged.
- Undefined: the comparison is unsigned. There is no inversion logic.

Decomposition:
- Package serial_cmp_pkg holds:
  - the state encoding, IDLE=1'b0 and COMPARE=1'b1;
  - a function computing NUM_CHUNKS (ceiling divide);
  - a function computing the index width, clog2(NUM_CHUNKS) with a minimum of 1.
- Sub-module chunk_compare: combinational CHUNK-bit compare giving a_gt and a_lt. It is instantiated once, with its inputs muxed by the chunk index.

Test Plan:
1. WIDTH=32, CHUNK=4, start with a=0x80000000, b=0x7FFFFFFF -> done 1 cycle after accept, gt=1, lt=0, eq=0.
2. a=b=0x12345678 with l=1, e=0, g=0 -> done after 8 cycles, lt=1. Repeat with e=1 only -> eq=1.
3. a=0x00000010, b=0x00000011 -> lt=1 after 8 cycles. Pulse start again at cycle 3 -> ignored; the result is unchanged.
4. Back-to-back: start asserted in the done cycle with a=5, b=3 -> second done 8 cycles later with gt=1. Assert rst at cycle 4 of a run -> busy=0, done never pulses, outputs 0.
5. SERIAL_CMP_SIGNED_EN defined, a=0xFFFFFFFF, b=0x00000001 -> lt=1 after 1 cycle. Undefined -> gt=1 after 1 cycle.
6. WIDTH=10, CHUNK=4 (padding): a=0x3FF, b=0x3FE -> gt=1 after 3 cycles. a=0x200, b=0x100 -> gt=1 after 1 cycle.
